// File: rtl/glyph_pkg.sv
// Shared sprite geometry, transparent key colour and fetch-state encoding
// for the glyph ROM read path.
package glyph_pkg;

    localparam int GLYPH_ROW_BITS   = 5;
    localparam int GLYPH_COL_BITS   = 5;
    localparam int GLYPH_SLOT_WORDS = 1024;

    localparam logic [23:0] GLYPH_KEY_COLOR = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // True when buffered plus in-flight pixels, less this cycle's pop, leave room for one more read
    function automatic logic credit_ok(
        input logic [1:0] fifo_count,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] pending;
        pending = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        return (pending < 3'd2);
    endfunction

endpackage

// File: rtl/glyph_fetch_fifo.sv
// Two-entry synchronous FIFO holding returned pixels until the compositor
// takes them; head entry is presented combinationally from storage.
module glyph_fetch_fifo #(
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= {WIDTH{1'b0}};
            mem_r[1] <= {WIDTH{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/glyph_row_fetcher.sv
// Fetches one 32-pixel sprite row from the synchronous glyph ROM and streams
// it, column-tagged with an opaque flag, to the compositor.
module glyph_row_fetcher
    import glyph_pkg::*;
#(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    ID_WIDTH   = 2,
    parameter int                    ROW_BITS   = GLYPH_ROW_BITS,
    parameter int                    COL_BITS   = GLYPH_COL_BITS,
    parameter int                    ADDR_WIDTH = ID_WIDTH + ROW_BITS + COL_BITS,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = GLYPH_KEY_COLOR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ID_WIDTH-1:0]   req_id,
    input  logic [ROW_BITS-1:0]   req_row,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [COL_BITS-1:0]   pix_col,
    output logic                  pix_opaque,
    output logic                  pix_last
);

    localparam int                  ENTRY_W  = DATA_WIDTH + COL_BITS;
    localparam logic [COL_BITS-1:0] COL_LAST = {COL_BITS{1'b1}};
    localparam logic [COL_BITS-1:0] COL_ONE  = {{(COL_BITS-1){1'b0}}, 1'b1};

    fetch_state_e          state_r;
    fetch_state_e          state_nxt_s;
    logic [ID_WIDTH-1:0]   id_r;
    logic [ROW_BITS-1:0]   row_r;
    logic [COL_BITS-1:0]   col_r;
    logic [COL_BITS-1:0]   col_nxt_s;
    logic [ADDR_WIDTH-1:0] rom_addr_r;
    logic                  inflight_r;
    logic [COL_BITS-1:0]   inflight_col_r;

    logic                  req_ready_s;
    logic                  accept_s;
    logic                  issue_s;
    logic                  last_col_s;
    logic                  pop_s;
    logic                  drained_s;
    logic                  pix_valid_s;
    logic [1:0]            fifo_count_s;
    logic [ENTRY_W-1:0]    fifo_wdata_s;
    logic [ENTRY_W-1:0]    fifo_rdata_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [COL_BITS-1:0]   head_col_s;

    assign head_data_s  = fifo_rdata_s[ENTRY_W-1:COL_BITS];
    assign head_col_s   = fifo_rdata_s[COL_BITS-1:0];
    assign pix_valid_s  = (fifo_count_s != 2'd0);
    assign pop_s        = pix_valid_s && pix_ready;
    assign accept_s     = req_valid && req_ready_s;
    assign last_col_s   = (col_r == COL_LAST);
    assign col_nxt_s    = col_r + COL_ONE;
    // Row is finished once nothing is in flight and the FIFO empties this cycle
    assign drained_s    = !inflight_r && ((fifo_count_s - {1'b0, pop_s}) == 2'd0);
    assign fifo_wdata_s = {rom_q, inflight_col_r};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (issue_s && last_col_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            DRAIN: begin
                if (drained_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State-decoded controls: request acceptance and credit-gated issue
    always_comb begin
        req_ready_s = 1'b0;
        issue_s     = 1'b0;
        case (state_r)
            IDLE:    req_ready_s = 1'b1;
            FETCH:   issue_s     = credit_ok(fifo_count_s, inflight_r, pop_s);
            DRAIN:   issue_s     = 1'b0;
            default: req_ready_s = 1'b0;
        endcase
    end

    // Row context, column counter and registered ROM address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r       <= {ID_WIDTH{1'b0}};
            row_r      <= {ROW_BITS{1'b0}};
            col_r      <= {COL_BITS{1'b0}};
            rom_addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            id_r       <= req_id;
            row_r      <= req_row;
            col_r      <= {COL_BITS{1'b0}};
            rom_addr_r <= {req_id, req_row, {COL_BITS{1'b0}}};
        end else if (issue_s && !last_col_s) begin
            col_r      <= col_nxt_s;
            rom_addr_r <= {id_r, row_r, col_nxt_s};
        end
    end

    // The presented address was consumed this cycle; its data lands next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r     <= 1'b0;
            inflight_col_r <= {COL_BITS{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_col_r <= col_r;
            end
        end
    end

    glyph_fetch_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_r),
        .wdata (fifo_wdata_s),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s)
    );

    assign req_ready  = req_ready_s;
    assign rom_addr   = rom_addr_r;
    assign pix_valid  = pix_valid_s;
    assign pix_data   = head_data_s;
    assign pix_col    = head_col_s;
    assign pix_opaque = pix_valid_s && (head_data_s != KEY_COLOR);
    assign pix_last   = pix_valid_s && (head_col_s == COL_LAST);

endmodule

// File: tb/tb_glyph_row_fetcher.sv
// Scoreboard bench for glyph_row_fetcher: expected pixels are derived from a
// behavioural ROM image at request acceptance and consumed by a monitor.
module tb_glyph_row_fetcher;

    localparam logic [23:0] KEY = 24'hFF00FF;

    typedef struct packed {
        logic [23:0] data;
        logic [4:0]  col;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_id;
    logic [4:0]  req_row;
    logic [11:0] rom_addr;
    logic [23:0] rom_q;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic [4:0]  pix_col;
    logic        pix_opaque;
    logic        pix_last;

    logic [23:0] rom_mem [4096];
    pix_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          pix_count   = 0;
    int          clear_count = 0;
    int          clear_col   = -1;

    glyph_row_fetcher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_id     (req_id),
        .req_row    (req_row),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_col    (pix_col),
        .pix_opaque (pix_opaque),
        .pix_last   (pix_last)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: one cycle read latency
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // On each accepted request, queue the 32 pixels the row must produce
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && req_valid && req_ready) begin
            for (int c = 0; c < 32; c++) begin
                pix_t e;
                e.data = rom_mem[int'(req_id) * 1024 + int'(req_row) * 32 + c];
                e.col  = 5'(c);
                exp_q.push_back(e);
            end
        end
    end

    // Pixel monitor: every transfer is checked against the queue head
    initial forever begin
        pix_t e;
        @(negedge clk);
        if (rst_n === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
            pix_count++;
            if (!pix_opaque) begin
                clear_count++;
                clear_col = int'(pix_col);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 32'(pix_col), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", 32'(pix_data), 32'(e.data));
                check("pix_col", 32'(pix_col), 32'(e.col));
                check("pix_opaque", 32'(pix_opaque), 32'(e.data != KEY));
                check("pix_last", 32'(pix_last), 32'(e.col == 5'd31));
            end
        end
    end

    // Outputs must hold while a presented pixel is not taken
    initial begin
        logic        stall_prev;
        logic [23:0] sd;
        logic [4:0]  sc;
        logic        so;
        logic        sl;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 32'(pix_valid), 32'd1);
                    check("stall_data", 32'(pix_data), 32'(sd));
                    check("stall_col", 32'(pix_col), 32'(sc));
                    check("stall_flags", 32'({pix_opaque, pix_last}), 32'({so, sl}));
                end
                stall_prev = (pix_valid === 1'b1) && (pix_ready === 1'b0);
                sd = pix_data;
                sc = pix_col;
                so = pix_opaque;
                sl = pix_last;
            end
        end
    end

    task automatic do_request(input int id, input int row, output int hs);
        req_id    = 2'(id);
        req_row   = 5'(row);
        req_valid = 1'b1;
        hs        = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) check("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (req_ready === 1'b1 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
    endtask

    initial begin
        int hs, rel, first_v, rr, last_rel, last_n, base_cnt, a5;
        int acc [3];
        int n_acc;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_id    = 2'd0;
        req_row   = 5'd0;
        pix_ready = 1'b0;
        for (int a = 0; a < 4096; a++) rom_mem[a] = 24'(a);

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_pix_col", 32'(pix_col), 32'd0);
        check("rst_pix_flags", 32'({pix_opaque, pix_last}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single row, free-flowing consumer: latency and throughput
        pix_ready = 1'b1;
        base_cnt  = pix_count;
        do_request(1, 3, hs);
        first_v = -1; rr = -1; last_rel = -1; last_n = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            rel = cyc - hs;
            if (rel == 1) check("t1_first_addr", 32'(rom_addr), 32'h460);
            if (pix_valid === 1'b1 && first_v < 0) first_v = rel;
            if (pix_valid === 1'b1 && pix_last === 1'b1) begin
                last_rel = rel;
                last_n++;
            end
            if (req_ready === 1'b1) begin
                rr = rel;
                break;
            end
        end
        check("t1_first_valid_cycle", 32'(first_v), 32'd3);
        check("t1_last_cycle", 32'(last_rel), 32'd34);
        check("t1_last_count", 32'(last_n), 32'd1);
        check("t1_ready_cycle", 32'(rr), 32'd35);
        check("t1_pixel_count", 32'(pix_count - base_cnt), 32'd32);

        // Backpressure: consumer stalls cycles 3..12
        @(posedge clk);
        #1;
        pix_ready = 1'b0;
        base_cnt  = pix_count;
        a5        = 0;
        do_request(2, 17, hs);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rel = cyc - hs;
            if (rel == 5) a5 = int'(rom_addr);
            if (rel == 12) begin
                check("t2_addr_frozen", 32'(rom_addr), 32'(a5));
                check("t2_addr_col2", 32'(rom_addr), 32'(2 * 1024 + 17 * 32 + 2));
                check("t2_valid_held", 32'(pix_valid), 32'd1);
                @(posedge clk);
                #1;
                pix_ready = 1'b1;
                break;
            end
        end
        wait_idle(1'b0);
        check("t2_pixel_count", 32'(pix_count - base_cnt), 32'd32);

        // Random ROM image, random consumer, random rows
        for (int a = 0; a < 4096; a++) begin
            rom_mem[a] = ($urandom_range(0, 15) == 0) ? KEY : 24'($urandom);
        end
        base_cnt = pix_count;
        for (int r = 0; r < 100; r++) begin
            do_request(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), hs);
            wait_idle(1'b1);
        end
        check("t3_pixel_count", 32'(pix_count - base_cnt), 32'd3200);

        // Transparency: only column 5 carries the key colour
        for (int c = 0; c < 32; c++) begin
            rom_mem[2 * 1024 + 7 * 32 + c] = (c == 5) ? KEY : 24'h100000 + 24'(c);
        end
        base_cnt = clear_count;
        do_request(2, 7, hs);
        wait_idle(1'b0);
        check("t4_clear_count", 32'(clear_count - base_cnt), 32'd1);
        check("t4_clear_col", 32'(clear_col), 32'd5);

        // Reset mid-row with two pixels buffered and column counter at 10
        base_cnt = pix_count;
        do_request(3, 12, hs);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rel = cyc - hs;
            if (rel == 10) begin
                @(posedge clk);
                #1;
                pix_ready = 1'b0;
            end
            if (rel == 13) break;
        end
        check("t5_pre_valid", 32'(pix_valid), 32'd1);
        check("t5_pre_addr", 32'(rom_addr), 32'(3 * 1024 + 12 * 32 + 10));
        check("t5_pre_count", 32'(pix_count - base_cnt), 32'd8);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_req_ready", 32'(req_ready), 32'd1);
        check("t5_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("t5_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("t5_rst_pix_data", 32'(pix_data), 32'd0);
        check("t5_rst_pix_col", 32'(pix_col), 32'd0);
        check("t5_rst_pix_flags", 32'({pix_opaque, pix_last}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        pix_ready = 1'b1;
        rst_n     = 1'b1;
        base_cnt  = pix_count;
        do_request(0, 9, hs);
        wait_idle(1'b0);
        check("t5_post_count", 32'(pix_count - base_cnt), 32'd32);

        // req_valid held high: one acceptance per row, spaced by the drain gap
        base_cnt  = pix_count;
        req_id    = 2'd1;
        req_row   = 5'd30;
        req_valid = 1'b1;
        n_acc     = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req_valid && req_ready === 1'b1) begin
                acc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 3) begin
                    @(posedge clk);
                    #1;
                    req_valid = 1'b0;
                    break;
                end
            end
        end
        req_valid = 1'b0;
        check("t6_accept_count", 32'(n_acc), 32'd3);
        if (n_acc == 3) begin
            check("t6_gap_1", 32'(acc[1] - acc[0]), 32'd35);
            check("t6_gap_2", 32'(acc[2] - acc[1]), 32'd35);
        end
        wait_idle(1'b0);
        check("t6_pixel_count", 32'(pix_count - base_cnt), 32'd96);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
